// File: rtl/uart_rgb_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_rgb_cmd_pkg
// Shared types and constants for the UART RGB command decoder:
//   - state_t   : command parser states (IDLE, HI, LO, SEND)
//   - chan_t    : colour channel selected by an 'R' / 'G' / 'B' command
//   - ASCII_*   : command, reply and line-ending characters
//   - UART_EMPTY: simpleuart receive register value when no byte is waiting
//   - is_hex / hex_nibble: ASCII hex digit recognition and decode
// ---------------------------------------------------------------------------
package uart_rgb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    SEND = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_t;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_G  = 8'h47;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_X  = 8'h58;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_QM = 8'h3F;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [31:0] UART_EMPTY = 32'hFFFF_FFFF;

  // True for 0-9, A-F and a-f.
  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Nibble value of an ASCII hex digit; result is don't-care for non-hex input.
  function automatic logic [3:0] hex_nibble(input logic [7:0] c);
    logic [7:0] t;
    if (c <= 8'h39)      t = c - 8'h30;
    else if (c <= 8'h46) t = c - 8'h37;
    else                 t = c - 8'h57;
    return t[3:0];
  endfunction

endpackage

// File: rtl/uart_rgb_cmd_pwm3.sv
// ---------------------------------------------------------------------------
// rgb_pwm3
// Three-channel PWM generator sharing one free-running counter.
//   clk, resetn            : clock, asynchronous active-low reset
//   duty_r/duty_g/duty_b   : per-channel duty values
//   pwm_red/green/blue     : registered outputs, high while counter < duty
// Duty 0 is always off; the maximum duty is high for all but one count,
// so a 100% output is not reachable. Duty changes apply on the next compare.
// ---------------------------------------------------------------------------
module rgb_pwm3 #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [PWM_BITS-1:0] duty_r,
  input  logic [PWM_BITS-1:0] duty_g,
  input  logic [PWM_BITS-1:0] duty_b,
  output logic                pwm_red,
  output logic                pwm_green,
  output logic                pwm_blue
);

  logic [PWM_BITS-1:0] cnt;

  // Wraps naturally from all-ones back to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt <= '0;
    else         cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_red   <= 1'b0;
      pwm_green <= 1'b0;
      pwm_blue  <= 1'b0;
    end else begin
      pwm_red   <= (cnt < duty_r);
      pwm_green <= (cnt < duty_g);
      pwm_blue  <= (cnt < duty_b);
    end
  end

endmodule

// File: rtl/uart_rgb_cmd.sv
// ---------------------------------------------------------------------------
// uart_rgb_cmd
// Polls the simpleuart register port for ASCII commands, updates three
// 8-bit brightness values and answers each command with one status byte.
//   Commands: 'R'|'G'|'B' hh  -> set channel duty, reply 'K'
//             'X'             -> clear all duties, reply 'K'
//             CR / LF in IDLE -> ignored
//             anything else   -> reply '?'
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   reg_dat_do            : UART receive data (all ones = empty)
//   reg_dat_wait          : UART transmitter busy
//   reg_dat_re            : one-cycle read strobe for the received byte
//   reg_dat_we/reg_dat_di : transmit request and data, held until accepted
//   pwm_red/green/blue    : PWM outputs (active high = LED on)
//   busy                  : high while the parser is outside IDLE
// Optional feature: define CMD_TIMEOUT_EN to discard a partial command after
// TIMEOUT_CYCLES idle cycles in HI or LO (no reply, no duty change).
// ---------------------------------------------------------------------------
module uart_rgb_cmd
  import uart_rgb_cmd_pkg::*;
#(
  parameter int          PWM_BITS       = 8,
  parameter int unsigned RESET_DUTY     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 24000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] reg_dat_do,
  input  logic        reg_dat_wait,
  output logic        reg_dat_re,
  output logic        reg_dat_we,
  output logic [31:0] reg_dat_di,
  output logic        pwm_red,
  output logic        pwm_green,
  output logic        pwm_blue,
  output logic        busy
);

  localparam logic [PWM_BITS-1:0] DUTY_INIT = PWM_BITS'(RESET_DUTY);

  state_t              state, state_next;
  chan_t               sel, sel_next;
  logic [3:0]          hi, hi_next;
  logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
  logic [PWM_BITS-1:0] duty_r_next, duty_g_next, duty_b_next;
  logic                re_next, we_next;
  logic [31:0]         di_next;
  logic                rx_valid;
  logic [7:0]          rx_byte;
  logic                timed_out;

  // The UART keeps its valid flag up through the cycle in which re is high,
  // so data seen during that cycle is the byte already taken.
  assign rx_byte  = reg_dat_do[7:0];
  assign rx_valid = !reg_dat_re && (reg_dat_do != UART_EMPTY);

`ifdef CMD_TIMEOUT_EN
  localparam logic [24:0] TIMEOUT_VAL = 25'(TIMEOUT_CYCLES);
  logic [24:0] idle_cnt;

  assign timed_out = (idle_cnt == TIMEOUT_VAL);

  // Counts cycles spent waiting for a digit; any accepted byte restarts it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      idle_cnt <= '0;
    else if ((state == HI || state == LO) && !rx_valid && !timed_out)
      idle_cnt <= idle_cnt + 1'b1;
    else
      idle_cnt <= '0;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    sel_next    = sel;
    hi_next     = hi;
    duty_r_next = duty_r;
    duty_g_next = duty_g;
    duty_b_next = duty_b;
    re_next     = 1'b0;
    we_next     = reg_dat_we;
    di_next     = reg_dat_di;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          re_next = 1'b1;
          if (rx_byte == ASCII_R) begin
            sel_next   = CH_R;
            state_next = HI;
          end else if (rx_byte == ASCII_G) begin
            sel_next   = CH_G;
            state_next = HI;
          end else if (rx_byte == ASCII_B) begin
            sel_next   = CH_B;
            state_next = HI;
          end else if (rx_byte == ASCII_X) begin
            duty_r_next = '0;
            duty_g_next = '0;
            duty_b_next = '0;
            di_next     = {24'b0, ASCII_K};
            we_next     = 1'b1;
            state_next  = SEND;
          end else if (rx_byte == ASCII_CR || rx_byte == ASCII_LF) begin
            state_next = IDLE;
          end else begin
            di_next    = {24'b0, ASCII_QM};
            we_next    = 1'b1;
            state_next = SEND;
          end
        end
      end

      HI: begin
        if (rx_valid) begin
          re_next = 1'b1;
          if (is_hex(rx_byte)) begin
            hi_next    = hex_nibble(rx_byte);
            state_next = LO;
          end else begin
            di_next    = {24'b0, ASCII_QM};
            we_next    = 1'b1;
            state_next = SEND;
          end
        end else if (timed_out) begin
          state_next = IDLE;
        end
      end

      LO: begin
        if (rx_valid) begin
          re_next = 1'b1;
          if (is_hex(rx_byte)) begin
            case (sel)
              CH_R:    duty_r_next = PWM_BITS'({hi, hex_nibble(rx_byte)});
              CH_G:    duty_g_next = PWM_BITS'({hi, hex_nibble(rx_byte)});
              default: duty_b_next = PWM_BITS'({hi, hex_nibble(rx_byte)});
            endcase
            di_next = {24'b0, ASCII_K};
          end else begin
            di_next = {24'b0, ASCII_QM};
          end
          we_next    = 1'b1;
          state_next = SEND;
        end else if (timed_out) begin
          state_next = IDLE;
        end
      end

      SEND: begin
        // The byte is taken on the edge that ends a we && !wait cycle.
        if (reg_dat_we && !reg_dat_wait) begin
          we_next    = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      sel        <= CH_R;
      hi         <= '0;
      duty_r     <= DUTY_INIT;
      duty_g     <= DUTY_INIT;
      duty_b     <= DUTY_INIT;
      reg_dat_re <= 1'b0;
      reg_dat_we <= 1'b0;
      reg_dat_di <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      sel        <= sel_next;
      hi         <= hi_next;
      duty_r     <= duty_r_next;
      duty_g     <= duty_g_next;
      duty_b     <= duty_b_next;
      reg_dat_re <= re_next;
      reg_dat_we <= we_next;
      reg_dat_di <= di_next;
      // Computed from the next state so busy tracks state without lag.
      busy       <= (state_next != IDLE);
    end
  end

  rgb_pwm3 #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk      (clk),
    .resetn   (resetn),
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b),
    .pwm_red  (pwm_red),
    .pwm_green(pwm_green),
    .pwm_blue (pwm_blue)
  );

endmodule

// File: tb/tb_uart_rgb_cmd.sv
// ---------------------------------------------------------------------------
// tb_uart_rgb_cmd
// Directed bench for uart_rgb_cmd: drives the simpleuart register port,
// watches transmit acceptances and measures PWM high time per period.
// Inputs change 1 time unit after a rising edge; checks run on falling edges.
// ---------------------------------------------------------------------------
module tb_uart_rgb_cmd;

  logic        clk;
  logic        resetn;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;
  logic        reg_dat_re;
  logic        reg_dat_we;
  logic [31:0] reg_dat_di;
  logic        pwm_red;
  logic        pwm_green;
  logic        pwm_blue;
  logic        busy;

  int checks_total  = 0;
  int checks_passed = 0;
  int tx_count      = 0;
  int exp_tx        = 0;
  logic [7:0] last_tx = 8'h00;

  uart_rgb_cmd #(
    .PWM_BITS(8),
    .RESET_DUTY(0),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .reg_dat_do  (reg_dat_do),
    .reg_dat_wait(reg_dat_wait),
    .reg_dat_re  (reg_dat_re),
    .reg_dat_we  (reg_dat_we),
    .reg_dat_di  (reg_dat_di),
    .pwm_red     (pwm_red),
    .pwm_green   (pwm_green),
    .pwm_blue    (pwm_blue),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmit monitor: a cycle with we && !wait is one accepted byte.
  always @(negedge clk) begin
    if (resetn && reg_dat_we && !reg_dat_wait) begin
      tx_count = tx_count + 1;
      last_tx  = reg_dat_di[7:0];
      $display("tx byte 0x%02h (count %0d)", reg_dat_di[7:0], tx_count);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
      $display("check %s: got 0x%0h", tag, obs);
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the DUT has strobed re for it.
  task automatic rx(input logic [7:0] b);
    bit seen = 0;
    @(posedge clk); #1;
    reg_dat_do = {24'b0, b};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (reg_dat_re) begin
        seen = 1;
        break;
      end
    end
    @(posedge clk); #1;
    reg_dat_do = 32'hFFFF_FFFF;
    $display("rx byte 0x%02h read=%0d", b, seen);
    if (!seen) check("rx_read_timeout", 32'd0, 32'd1);
  endtask

  // Expect exactly one more reply with value b, then parser back in IDLE.
  task automatic expect_reply(input string tag, input logic [7:0] b);
    exp_tx++;
    for (int i = 0; i < 100 && (tx_count < exp_tx || busy); i++) @(negedge clk);
    check({tag, "_txcount"}, tx_count, exp_tx);
    check({tag, "_txbyte"}, {24'b0, last_tx}, {24'b0, b});
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic pwm_count(output int r, output int g, output int b, input int n);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r += int'(pwm_red);
      g += int'(pwm_green);
      b += int'(pwm_blue);
    end
  endtask

  initial begin
    int cr, cg, cb, stable;
    resetn       = 1'b0;
    reg_dat_do   = 32'hFFFF_FFFF;
    reg_dat_wait = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_re", {31'b0, reg_dat_re}, 32'd0);
    check("rst_we", {31'b0, reg_dat_we}, 32'd0);
    check("rst_di", reg_dat_di, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_pwm", {29'b0, pwm_red, pwm_green, pwm_blue}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // R80 -> 'K', red 128/256
    rx("R");
    @(negedge clk);
    check("busy_in_hi", {31'b0, busy}, 32'd1);
    rx("8");
    rx("0");
    expect_reply("r80", "K");
    pwm_count(cr, cg, cb, 256);
    check("r80_red", cr, 128);
    check("r80_green", cg, 0);
    check("r80_blue", cb, 0);

    // lowercase command -> '?', then GfF -> 'K', green 255/256
    rx("g");
    expect_reply("lower_g", "?");
    rx("G");
    rx("f");
    rx("F");
    expect_reply("gff", "K");
    pwm_count(cr, cg, cb, 256);
    check("gff_green", cg, 255);
    check("gff_red", cr, 128);

    // B1Z -> '?', blue unchanged
    rx("B");
    rx("1");
    rx("Z");
    expect_reply("b1z", "?");
    pwm_count(cr, cg, cb, 256);
    check("b1z_blue", cb, 0);

    // CR in IDLE dropped silently
    rx(8'h0D);
    repeat (20) @(negedge clk);
    check("cr_idle_notx", tx_count, exp_tx);
    check("cr_idle_busy", {31'b0, busy}, 32'd0);

    // LF in HI is an error; red keeps its value
    rx("R");
    rx(8'h0A);
    expect_reply("lf_hi", "?");
    pwm_count(cr, cg, cb, 256);
    check("lf_hi_red", cr, 128);

    // R40, G40, then X clears everything
    rx("R"); rx("4"); rx("0");
    expect_reply("r40", "K");
    rx("G"); rx("4"); rx("0");
    expect_reply("g40", "K");
    pwm_count(cr, cg, cb, 256);
    check("pre_x_red", cr, 64);
    check("pre_x_green", cg, 64);
    rx("X");
    expect_reply("x", "K");
    pwm_count(cr, cg, cb, 512);
    check("x_all_off", cr + cg + cb, 0);

    // Transmit stall: wait held for 50 cycles during a 'K' reply
    reg_dat_wait = 1'b1;
    rx("R"); rx("2"); rx("0");
    stable = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (reg_dat_we === 1'b1 && reg_dat_di === 32'h0000_004B) stable++;
    end
    check("stall_stable", stable, 50);
    check("stall_no_tx", tx_count, exp_tx);
    @(posedge clk); #1;
    reg_dat_wait = 1'b0;
    @(negedge clk);
    check("stall_we_hold", {31'b0, reg_dat_we}, 32'd1);
    @(negedge clk);
    check("stall_we_drop", {31'b0, reg_dat_we}, 32'd0);
    exp_tx++;
    repeat (10) @(negedge clk);
    check("stall_one_tx", tx_count, exp_tx);
    check("stall_byte", {24'b0, last_tx}, 32'h4B);
    pwm_count(cr, cg, cb, 256);
    check("stall_red", cr, 32);

    // Reset with a pending transmit
    reg_dat_wait = 1'b1;
    rx("X");
    @(negedge clk);
    check("pre_rst_we", {31'b0, reg_dat_we}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_tx_we", {31'b0, reg_dat_we}, 32'd0);
    check("rst_tx_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    reg_dat_wait = 1'b0;
    resetn = 1'b1;

    // Reset while in LO, after giving red a nonzero duty
    rx("R"); rx("C"); rx("0");
    expect_reply("rc0", "K");
    rx("R"); rx("F");
    @(negedge clk);
    check("pre_rst_lo_busy", {31'b0, busy}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_lo_all", {27'b0, reg_dat_re, reg_dat_we, busy, pwm_red, pwm_green | pwm_blue}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    pwm_count(cr, cg, cb, 256);
    check("rst_lo_duty_cleared", cr + cg + cb, 0);
    rx("R"); rx("F"); rx("F");
    expect_reply("after_rst_rff", "K");
    pwm_count(cr, cg, cb, 256);
    check("after_rst_red", cr, 255);

`ifdef CMD_TIMEOUT_EN
    rx("R");
    repeat (110) @(negedge clk);
    check("timeout_busy", {31'b0, busy}, 32'd0);
    check("timeout_notx", tx_count, exp_tx);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
